// File: rtl/v810_pkg.sv
// v810_pkg: shared types and constants for the V810 memory access unit arbiter.
package v810_pkg;
  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_I    = 2'd1,
    MAU_D    = 2'd2
  } mau_owner_t;
  localparam int MAU_DSTREAK_W = 4;
endpackage

// File: rtl/v810_mau_arb.sv
// v810_mau_arb: shares one external memory bus between V810 instruction fetch and data access.
// Data has fixed priority. After DSTREAK_MAX back-to-back data grants against a waiting
// fetch, the fetch is forced through (0 disables this). DLOCK keeps the bus reserved for
// data across a read-modify-write pair.
// Ports: CLK/RESn (async active-low)/CE clocking; ICIA/ICIREQ/ICID/ICIACK instruction side;
// DA/DREQ/DWR/DBE/DWD/DLOCK/DRD/DACK data side; MA/MREQ/MWR/MBE/MWD/MRD/MACK bus side;
// OWNER registered owner (0 idle, 1 instruction, 2 data).
// Optional: define V810_MAU_PERF_EN to add PERF_CLR, PERF_IWAIT and PERF_DWAIT wait counters.
module v810_mau_arb
  import v810_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] ICIA,
  input  logic        ICIREQ,
  output logic [31:0] ICID,
  output logic        ICIACK,
  input  logic [31:0] DA,
  input  logic        DREQ,
  input  logic        DWR,
  input  logic [3:0]  DBE,
  input  logic [31:0] DWD,
  input  logic        DLOCK,
  output logic [31:0] DRD,
  output logic        DACK,
  output logic [31:0] MA,
  output logic        MREQ,
  output logic        MWR,
  output logic [3:0]  MBE,
  output logic [31:0] MWD,
  input  logic [31:0] MRD,
  input  logic        MACK,
  output logic [1:0]  OWNER
`ifdef V810_MAU_PERF_EN
  ,
  input  logic        PERF_CLR,
  output logic [31:0] PERF_IWAIT,
  output logic [31:0] PERF_DWAIT
`endif
);
  localparam logic [MAU_DSTREAK_W-1:0] SMAX = MAU_DSTREAK_W'(DSTREAK_MAX);
  mau_owner_t st;
  logic lock_r;
  logic [MAU_DSTREAK_W-1:0] dstreak;
  logic is_i, is_d, arb_open, d_win;
  assign is_i = st == MAU_I;
  assign is_d = st == MAU_D;
  // Normal arbitration runs when no lock is held, or when a held lock is released
  // (DLOCK low) without a data request to consume it.
  assign arb_open = ~lock_r | ~DLOCK;
  // Data wins contention until it has taken SMAX grants in a row against a waiting fetch.
  assign d_win = DREQ & (~ICIREQ | SMAX == '0 | dstreak < SMAX);
  assign OWNER  = st;
  assign MREQ   = (is_i & ICIREQ) | (is_d & DREQ);
  assign MA     = is_i ? ICIA : is_d ? DA : 32'h0;
  assign MWR    = is_d & DWR;
  assign MBE    = is_i ? 4'hF : is_d ? DBE : 4'h0;
  assign MWD    = is_d ? DWD : 32'h0;
  assign ICIACK = is_i & MACK;
  assign DACK   = is_d & MACK;
  assign ICID   = is_i ? MRD : 32'h0;
  assign DRD    = is_d ? MRD : 32'h0;
  always_ff @(posedge CLK or negedge RESn)
    if (!RESn) begin
      st      <= MAU_IDLE;
      lock_r  <= 1'b0;
      dstreak <= '0;
    end else if (CE) begin
      case (st)
        MAU_IDLE: begin
          if (!ICIREQ) dstreak <= '0;
          if (lock_r & DREQ) st <= MAU_D;
          else if (arb_open) begin
            lock_r <= 1'b0;
            if (d_win) begin
              st <= MAU_D;
              if (ICIREQ && dstreak != '1) dstreak <= dstreak + 1'b1;
            end else if (ICIREQ) begin
              st      <= MAU_I;
              dstreak <= '0;
            end
          end
        end
        MAU_I: if (MACK | ~ICIREQ) st <= MAU_IDLE;
        MAU_D: begin
          if (MACK | ~DREQ) st <= MAU_IDLE;
          if (MACK) lock_r <= DLOCK;
        end
        default: st <= MAU_IDLE;
      endcase
    end
`ifdef V810_MAU_PERF_EN
  always_ff @(posedge CLK or negedge RESn)
    if (!RESn) begin
      PERF_IWAIT <= '0;
      PERF_DWAIT <= '0;
    end else if (PERF_CLR) begin
      PERF_IWAIT <= '0;
      PERF_DWAIT <= '0;
    end else if (CE) begin
      PERF_IWAIT <= PERF_IWAIT + 32'(ICIREQ & ~ICIACK);
      PERF_DWAIT <= PERF_DWAIT + 32'(DREQ & ~DACK);
    end
`endif
endmodule

// File: tb/tb_v810_mau_arb.sv
// tb_v810_mau_arb: directed bench comparing two arbiter instances (DSTREAK_MAX 4 and 0) against a behavioural model.
module tb_v810_mau_arb;
  typedef struct packed {
    logic [1:0] st;
    logic       lk;
    logic [3:0] sk;
  } m_t;
  logic clk = 1'b0;
  logic rst_n, ce, icireq, dreq, dwr, dlock, mack;
  logic [31:0] icia, da, dwd, mrd;
  logic [3:0] dbe;
  logic [31:0] icid[2], drd[2], ma[2], mwd[2];
  logic iciack[2], dack[2], mreq[2], mwr[2];
  logic [3:0] mbe[2];
  logic [1:0] owner[2], prev[2];
  m_t m[2];
  logic [1:0] glog0[$], glog1[$];
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
`ifdef V810_MAU_PERF_EN
    logic [31:0] piw, pdw;
`endif
    v810_mau_arb #(.DSTREAK_MAX(g == 0 ? 4 : 0)) u (
      .CLK(clk), .RESn(rst_n), .CE(ce),
      .ICIA(icia), .ICIREQ(icireq), .ICID(icid[g]), .ICIACK(iciack[g]),
      .DA(da), .DREQ(dreq), .DWR(dwr), .DBE(dbe), .DWD(dwd), .DLOCK(dlock),
      .DRD(drd[g]), .DACK(dack[g]),
      .MA(ma[g]), .MREQ(mreq[g]), .MWR(mwr[g]), .MBE(mbe[g]), .MWD(mwd[g]),
      .MRD(mrd), .MACK(mack), .OWNER(owner[g])
`ifdef V810_MAU_PERF_EN
      , .PERF_CLR(1'b0), .PERF_IWAIT(piw), .PERF_DWAIT(pdw)
`endif
    );
  end
  function automatic m_t step(m_t c, int mx);
    m_t n = c;
    if (c.st == 2'd0) begin
      if (!icireq) n.sk = 4'd0;
      if (c.lk && dreq) n.st = 2'd2;
      else if (!(c.lk && dlock)) begin
        n.lk = 1'b0;
        if (dreq && icireq && (mx == 0 || int'(c.sk) < mx)) begin
          n.st = 2'd2;
          n.sk = (c.sk == 4'd15) ? 4'd15 : c.sk + 4'd1;
        end else if (dreq && !icireq) n.st = 2'd2;
        else if (icireq) begin
          n.st = 2'd1;
          n.sk = 4'd0;
        end
      end
    end else begin
      if (mack || !(c.st == 2'd1 ? icireq : dreq)) n.st = 2'd0;
      if (c.st == 2'd2 && mack) n.lk = dlock;
    end
    return n;
  endfunction
  function automatic logic [137:0] expv(m_t c);
    logic i = c.st == 2'd1;
    logic d = c.st == 2'd2;
    return {c.st, (i & icireq) | (d & dreq), i ? icia : d ? da : 32'h0, d & dwr,
            i ? 4'hF : d ? dbe : 4'h0, d ? dwd : 32'h0, i ? mrd : 32'h0, i & mack,
            d ? mrd : 32'h0, d & mack};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m[0] <= '0;
      m[1] <= '0;
    end else if (ce) begin
      m[0] <= step(m[0], 4);
      m[1] <= step(m[1], 0);
    end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [137:0] act;
      act = {owner[k], mreq[k], ma[k], mwr[k], mbe[k], mwd[k], icid[k], iciack[k], drd[k], dack[k]};
      nvec++;
      if (act !== expv(m[k])) begin
        nerr++;
        $display("FAIL model dut%0d t=%0t got %h want %h", k, $time, act, expv(m[k]));
      end
      if (owner[k] != 2'd0 && prev[k] == 2'd0) begin
        if (k == 0) glog0.push_back(owner[k]);
        else glog1.push_back(owner[k]);
      end
    end
    prev[0] <= owner[0];
    prev[1] <= owner[1];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [1:0] exp_g[10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    rst_n = 1'b0; ce = 1'b1; icireq = 1'b0; dreq = 1'b0; dwr = 1'b0; dlock = 1'b0; mack = 1'b0;
    icia = '0; da = '0; dwd = '0; mrd = '0; dbe = '0;
    tick(2);
    rst_n = 1'b1;
    chk("reset_owner", 32'(owner[0]), 32'd0);
    chk("reset_mreq", 32'(mreq[0]), 32'd0);
    icireq = 1'b1; icia = 32'h0000_1000;
    tick();
    chk("fetch_owner", 32'(owner[0]), 32'd1);
    chk("fetch_ma", ma[0], 32'h0000_1000);
    chk("fetch_mbe", 32'(mbe[0]), 32'hF);
    chk("fetch_ack_wait", 32'(iciack[0]), 32'd0);
    mack = 1'b1; mrd = 32'hDEAD_BEEF;
    #1;
    chk("fetch_icid", icid[0], 32'hDEAD_BEEF);
    chk("fetch_ack", 32'(iciack[0]), 32'd1);
    tick();
    icireq = 1'b0; mack = 1'b0;
    #1;
    chk("fetch_turnaround", 32'(owner[0]), 32'd0);
    chk("fetch_ack_drop", 32'(iciack[0]), 32'd0);
    tick();
    glog0.delete(); glog1.delete();
    dreq = 1'b1; icireq = 1'b1; mack = 1'b1; da = 32'h0000_2000; mrd = 32'h5555_AAAA;
    tick(20);
    dreq = 1'b0; icireq = 1'b0; mack = 1'b0;
    chk("streak4_count", glog0.size(), 32'd10);
    chk("strict_count", glog1.size(), 32'd10);
    for (int i = 0; i < 10 && i < glog0.size(); i++) chk($sformatf("streak4_grant%0d", i), 32'(glog0[i]), 32'(exp_g[i]));
    for (int i = 0; i < glog1.size(); i++) chk($sformatf("strict_grant%0d", i), 32'(glog1[i]), 32'd2);
    tick();
    dreq = 1'b1; dwr = 1'b1; dlock = 1'b1; da = 32'h0000_3000; dwd = 32'h0000_CAFE; dbe = 4'h3;
    tick();
    chk("lock_wr_owner", 32'(owner[0]), 32'd2);
    chk("lock_wr_mwr", 32'(mwr[0]), 32'd1);
    chk("lock_wr_mbe", 32'(mbe[0]), 32'h3);
    chk("lock_wr_mwd", mwd[1], 32'h0000_CAFE);
    mack = 1'b1;
    tick();
    dreq = 1'b0; mack = 1'b0; dwr = 1'b0; icireq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lock_block%0d_d0", i), 32'(owner[0]), 32'd0);
      chk($sformatf("lock_block%0d_d1", i), 32'(owner[1]), 32'd0);
    end
    dreq = 1'b1; dlock = 1'b0;
    tick();
    chk("lock_rd_owner", 32'(owner[0]), 32'd2);
    mack = 1'b1; mrd = 32'h0000_1234;
    #1;
    chk("lock_rd_drd", drd[0], 32'h0000_1234);
    chk("lock_rd_iciack", 32'(iciack[0]), 32'd0);
    tick();
    dreq = 1'b0; mack = 1'b0;
    tick();
    chk("lock_release_ibus", 32'(owner[0]), 32'd1);
    chk("lock_release_ibus_d1", 32'(owner[1]), 32'd1);
    mack = 1'b1;
    tick();
    icireq = 1'b0; mack = 1'b0;
    tick();
    dreq = 1'b1; da = 32'h0000_4000;
    tick();
    chk("ce_owner_start", 32'(owner[0]), 32'd2);
    ce = 1'b0; mack = 1'b1;
    #1;
    chk("ce_dack_live", 32'(dack[0]), 32'd1);
    tick();
    chk("ce_no_complete", 32'(owner[0]), 32'd2);
    ce = 1'b1; mack = 1'b0;
    tick();
    chk("ce_still_dbus", 32'(owner[0]), 32'd2);
    mack = 1'b1;
    tick();
    chk("ce_complete", 32'(owner[0]), 32'd0);
    mack = 1'b0;
    tick();
    tick();
    chk("drop_owner", 32'(owner[0]), 32'd2);
    dreq = 1'b0;
    #1;
    chk("drop_mreq", 32'(mreq[0]), 32'd0);
    tick();
    chk("drop_idle", 32'(owner[0]), 32'd0);
    dreq = 1'b1;
    tick();
    chk("rst_mid_mreq_pre", 32'(mreq[0]), 32'd1);
    mack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mreq", 32'(mreq[0]), 32'd0);
    chk("rst_mid_owner", 32'(owner[0]), 32'd0);
    chk("rst_mid_dack", 32'(dack[0]), 32'd0);
    tick();
    rst_n = 1'b1; dreq = 1'b0; mack = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/v810_mau_arb.md
Name: v810_mau_arb

Overview:
- Memory access unit arbiter for the V810 core.
- Shares one external memory bus between two requesters:
  - the instruction cache bus (ICIA/ICIREQ/ICID/ICIACK);
  - the execution unit data bus.
- Grants one owner per transaction. Data has fixed priority, with a bounded-starvation guarantee for instruction fetch.
- Supports a data bus lock for read-modify-write sequences (CAXI).

Parameters:
- DSTREAK_MAX, 4: consecutive data grants allowed while ICIREQ is pending before instruction is forced to win. 0 = strict data priority. Legal range 0..15.

Ports:
- CLK  in  1  system clock
- RESn  in  1  reset; asynchronous, active-low
- CE  in  1  global clock enable
- ICIA  in  32  instruction fetch address
- ICIREQ  in  1  instruction access request
- ICID  out  32  instruction read data
- ICIACK  out  1  instruction access acknowledge
- DA  in  32  data address
- DREQ  in  1  data access request
- DWR  in  1  1 = write
- DBE  in  4  data byte enables
- DWD  in  32  data write data
- DLOCK  in  1  keep bus for data after this transfer
- DRD  out  32  data read data
- DACK  out  1  data access acknowledge
- MA  out  32  bus address
- MREQ  out  1  bus request
- MWR  out  1  bus write
- MBE  out  4  bus byte enables
- MWD  out  32  bus write data
- MRD  in  32  bus read data
- MACK  in  1  bus acknowledge
- OWNER  out  2  current owner: 0 idle, 1 instruction, 2 data

Behaviour:
- State machine, registered, advances only when CE=1:
  - IDLE: no owner.
  - IBUS: instruction owns the bus.
  - DBUS: data owns the bus.
- Async reset (RESn=0): state=IDLE, lock_r=0, dstreak=0. All outputs 0 immediately, including during a bus cycle in progress. MREQ dropping mid-transfer aborts it; the bus must tolerate this.
- IDLE arbitration, evaluated at the CE edge:
  - if lock_r and DREQ: DBUS.
  - else if lock_r and ~DLOCK: clear lock_r, then arbitrate normally in the same cycle.
  - else if lock_r: stay IDLE, instruction is blocked.
  - else if DREQ and ICIREQ: DBUS if DSTREAK_MAX=0 or dstreak<DSTREAK_MAX, else IBUS.
  - else if DREQ: DBUS.
  - else if ICIREQ: IBUS.
  - else: IDLE.
- dstreak (4-bit) updates:
  - +1 on each DBUS grant made while ICIREQ=1 and lock_r=0, saturating at 15.
  - cleared on any IBUS grant, and on any IDLE cycle with ICIREQ=0.
- IBUS/DBUS forwarding (combinational from the owner's inputs):
  - MREQ=1.
  - MA, MWR, MBE, MWD from the owner. Instruction fetch drives MWR=0, MBE=4'hF, MWD=0.
  - The owner's ACK follows MACK; the other ACK is 0.
  - ICID=MRD in IBUS, DRD=MRD in DBUS; the other read bus is 0.
- In IDLE: MREQ=MWR=0, MA=MBE=MWD=0, ICIACK=DACK=0, ICID=DRD=0.
- Completion: MACK=1 with CE=1 ends the transfer.
  - Next state is IDLE. There is always one IDLE turnaround cycle per transfer, so minimum transfer period is 2 CE cycles.
  - On DBUS completion, lock_r<=DLOCK.
- The owner holds its REQ and its inputs stable until its ACK. If the owner drops REQ before MACK, MREQ follows it low, and the state returns to IDLE at the next CE edge.
- CE=0: state and counters freeze. Combinational forwarding stays live. An ACK seen while CE=0 does not complete the transfer.
- OWNER is registered and equals the state encoding.

Optional Feature:
- Macro: V810_MAU_PERF_EN.
- With the macro defined, adds outputs PERF_IWAIT[31:0] and PERF_DWAIT[31:0]:
  - each counts CE cycles where that requester's REQ=1 and its ACK=0;
  - wrap at 2^32;
  - reset to 0;
  - cleared synchronously by added input PERF_CLR (priority over increment).
- Without the macro: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- v810_pkg gets:
  - typedef mau_owner_t (2-bit enum: MAU_IDLE=0, MAU_I=1, MAU_D=2);
  - constant MAU_DSTREAK_W=4.
- No sub-module; the block is a single flat module.

Test Plan:
- Reset mid-transfer: DBUS active with MREQ=1, assert RESn=0 -> MREQ=0, OWNER=0, DACK=0 within the same cycle (no clock edge needed).
- Single instruction fetch: ICIREQ=1, ICIA=32'h0000_1000, MACK on 2nd bus cycle with MRD=32'hDEAD_BEEF -> MA=32'h1000, MBE=4'hF, ICID=32'hDEADBEEF, ICIACK pulses 1 cycle, then OWNER=0 for 1 cycle.
- Contention, DSTREAK_MAX=4, DREQ and ICIREQ held high, MACK=1 every bus cycle -> grant order D,D,D,D,I,D,D,D,D,I...
- Contention, DSTREAK_MAX=0 -> only D grants; instruction never granted while DREQ=1.
- Lock: data write with DLOCK=1 completes, then ICIREQ=1 and DREQ=0 for 3 cycles -> no IBUS grant. DREQ=1 with DLOCK=0 -> DBUS granted; after it completes, IBUS is granted.
- CE gating: CE toggles 1,0,1 during DBUS with MACK=1 only while CE=0 -> no completion, state stays DBUS. MACK=1 with CE=1 -> completes.
